// File: rtl/xor_gate_pkg.sv
// Shared limits for the xor_gate bring-up cell.
// Both parameter ranges are checked against these at elaboration.
package xor_gate_pkg;

    localparam int WIDTH_MAX   = 64;
    localparam int LATENCY_MAX = 8;

endpackage : xor_gate_pkg

// File: rtl/xor_gate_pipe_stage.sv
// One pipeline register of the xor_gate datapath.
// It is a plain WIDTH-bit register with an asynchronous active-high clear.
module xor_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : xor_pipe_stage

// File: rtl/xor_gate.sv
// Registered bitwise XOR of a and b with LATENCY register stages.
// There is no combinational path from a or b to y.
module xor_gate
    import xor_gate_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Out-of-range parameters stop elaboration instead of being clamped.
    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("xor_gate: WIDTH=%0d outside 1..%0d", WIDTH, WIDTH_MAX);
    end
    if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("xor_gate: LATENCY=%0d outside 1..%0d", LATENCY, LATENCY_MAX);
    end

    logic [WIDTH-1:0] xor_d;
    logic [WIDTH-1:0] stage_q [LATENCY];

    always_comb begin
        xor_d = a ^ b;
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_first
            xor_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .d   (xor_d),
                .q   (stage_q[k])
            );
        end else begin : g_next
            xor_pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk (clk),
                .rst (rst),
                .d   (stage_q[k-1]),
                .q   (stage_q[k])
            );
        end
    end

    assign y = stage_q[LATENCY-1];

endmodule : xor_gate

// File: tb/tb_xor_gate.sv
// Self-checking bench for xor_gate: three instances (1/1, 8/2, 8/3) share clk and rst.
// Expected values come from a per-edge history of sampled a^b since the last reset.
module tb_xor_gate;

    logic       clk;
    logic       rst;
    logic       a1, b1, y1;
    logic [7:0] a2, b2, y2;
    logic [7:0] a3, b3, y3;

    int checks = 0;
    int fails  = 0;

    xor_gate #(.WIDTH(1), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .y(y1));
    xor_gate #(.WIDTH(8), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .a(a2), .b(b2), .y(y2));
    xor_gate #(.WIDTH(8), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .a(a3), .b(b3), .y(y3));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: record a^b at every post-reset edge; y shows the entry LATENCY-1 edges back, else 0.
    logic       h1 [0:1023];
    logic [7:0] h2 [0:1023];
    logic [7:0] h3 [0:1023];
    int         n = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n <= 0;
        end else begin
            h1[n] <= a1 ^ b1;
            h2[n] <= a2 ^ b2;
            h3[n] <= a3 ^ b3;
            n     <= n + 1;
        end
    end

    function automatic logic exp1();
        return (n >= 1) ? h1[n-1] : 1'b0;
    endfunction

    function automatic logic [7:0] exp2();
        return (n >= 2) ? h2[n-2] : 8'h00;
    endfunction

    function automatic logic [7:0] exp3();
        return (n >= 3) ? h3[n-3] : 8'h00;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        a1 = 1'b0; b1 = 1'b0;
        a2 = 8'h00; b2 = 8'h00;
        a3 = 8'h00; b3 = 8'h00;
        #1 rst = 1'b1;
        #1;
        checks++; if (y1 !== 1'b0)  begin fails++; $display("FAIL reset_y1: got %h expected 0", y1); end
        checks++; if (y2 !== 8'h00) begin fails++; $display("FAIL reset_y2: got %h expected 00", y2); end
        checks++; if (y3 !== 8'h00) begin fails++; $display("FAIL reset_y3: got %h expected 00", y3); end
        #1 rst = 1'b0;
        #1;
        checks++; if (y1 !== 1'b0)  begin fails++; $display("FAIL release_y1: got %h expected 0", y1); end
        checks++; if (y2 !== 8'h00) begin fails++; $display("FAIL release_y2: got %h expected 00", y2); end
        checks++; if (y3 !== 8'h00) begin fails++; $display("FAIL release_y3: got %h expected 00", y3); end
        @(negedge clk);
        checks++; if (y3 !== 8'h00) begin fails++; $display("FAIL first_edge_y3: got %h expected 00", y3); end
    endtask

    task automatic test_truth_table();
        for (int i = 0; i < 25; i++) begin
            a1 = ((i % 2) == 0);
            b1 = (((i / 2) % 2) == 0);
            @(negedge clk);
            checks++;
            if (y1 !== (((i % 2) == 0) ^ (((i / 2) % 2) == 0))) begin
                fails++;
                $display("FAIL truth_table[%0d]: got %b expected %b", i, y1, a1 ^ b1);
            end
        end
    endtask

    task automatic test_latency();
        logic [7:0] want;
        a3 = 8'h00; b3 = 8'h00;
        repeat (3) @(negedge clk);
        a3 = 8'hF0; b3 = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a3 = 8'h00; b3 = 8'h00;
            want = (k == 2) ? 8'hCC : 8'h00;
            checks++;
            if (y3 !== want) begin
                fails++;
                $display("FAIL latency_edge%0d: got %h expected %h", k, y3, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        logic [7:0] idx;
        a2 = 8'h00; b2 = 8'h00;
        @(negedge clk);
        for (int i = 0; i <= 16; i++) begin
            idx = 8'(i);
            a2 = (i < 16) ? idx : 8'h00;
            b2 = (i < 16) ? 8'hFF : 8'h00;
            @(negedge clk);
            idx  = 8'(i - 1);
            want = (i == 0) ? 8'h00 : ~idx;
            checks++;
            if (y2 !== want) begin
                fails++;
                $display("FAIL stream[%0d]: got %h expected %h", i, y2, want);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] first;
        for (int i = 0; i < 4; i++) begin
            a3 = 8'($urandom); b3 = 8'($urandom) | 8'h01;
            a2 = 8'($urandom); b2 = 8'($urandom) | 8'h01;
            a1 = 1'b1;         b1 = 1'b0;
            @(negedge clk);
        end
        a3 = 8'($urandom); b3 = ~a3;
        first = a3 ^ b3;
        #2 rst = 1'b1;
        #1;
        checks++; if (y1 !== 1'b0)  begin fails++; $display("FAIL midrst_y1: got %h expected 0", y1); end
        checks++; if (y2 !== 8'h00) begin fails++; $display("FAIL midrst_y2: got %h expected 00", y2); end
        checks++; if (y3 !== 8'h00) begin fails++; $display("FAIL midrst_y3: got %h expected 00", y3); end
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            a3 = 8'($urandom); b3 = 8'($urandom);
            checks++;
            if (y3 !== ((k == 2) ? first : 8'h00)) begin
                fails++;
                $display("FAIL midrst_edge%0d: got %h expected %h", k, y3, (k == 2) ? first : 8'h00);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] sa, sb;
        for (int i = 0; i < 4; i++) begin
            sa = 8'($urandom); sb = 8'($urandom);
            a2 = sa; b2 = sb; a3 = sa; b3 = sb; a1 = sa[0]; b1 = sb[0];
            #2;
            a2 = ~sa; b2 = sa; a3 = ~sb; b3 = 8'($urandom); a1 = ~sa[0]; b1 = sa[0];
            #2;
            a2 = sa; b2 = sb; a3 = sa; b3 = sb; a1 = sa[0]; b1 = sb[0];
            @(negedge clk);
            checks++;
            if (y1 !== (sa[0] ^ sb[0])) begin
                fails++;
                $display("FAIL glitch_y1[%0d]: got %b expected %b", i, y1, sa[0] ^ sb[0]);
            end
            checks++;
            if (y2 !== exp2()) begin
                fails++;
                $display("FAIL glitch_y2[%0d]: got %h expected %h", i, y2, exp2());
            end
            checks++;
            if (y3 !== exp3()) begin
                fails++;
                $display("FAIL glitch_y3[%0d]: got %h expected %h", i, y3, exp3());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            a1 = 1'($urandom); b1 = 1'($urandom);
            a2 = 8'($urandom); b2 = 8'($urandom);
            a3 = 8'($urandom); b3 = 8'($urandom);
            @(negedge clk);
            checks++;
            if (y1 !== exp1()) begin fails++; $display("FAIL random_y1[%0d]: got %b expected %b", i, y1, exp1()); end
            checks++;
            if (y2 !== exp2()) begin fails++; $display("FAIL random_y2[%0d]: got %h expected %h", i, y2, exp2()); end
            checks++;
            if (y3 !== exp3()) begin fails++; $display("FAIL random_y3[%0d]: got %h expected %h", i, y3, exp3()); end
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_latency();
        test_back_to_back();
        test_mid_reset();
        test_glitch();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_xor_gate
